// File: rtl/tx4p_fifo_pkg.sv
// Shared defaults and FSM state encoding for the FIFO-backed 4-phase transmitter.
package tx4p_fifo_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WACK = 2'b10
    } state_t;

endpackage

// File: rtl/tx4p_fifo_sync_nff.sv
// N-flop level synchronizer for a single asynchronous control bit.
module tx4p_fifo_sync_nff
    import tx4p_fifo_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tx4p_fifo.sv
// Transmitter: core writes into a DEPTH-entry FIFO, words leave over a 4-phase
// req/ack handshake with a synchronized ack, plus level, overflow and timeout status.
module tx4p_fifo
    import tx4p_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       v,
    input  logic [DATA_WIDTH-1:0]      input_tx,
    output logic                       ready,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       ack,
    output logic [DATA_WIDTH-1:0]      output_tx,
    output logic                       req,
    output logic                       f,
    output logic                       ovf,
    output logic                       tmo
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  req_q, req_d;
    logic                  f_q, ovf_q, a_prev_q, a_sync;
    logic                  full, push, pop;

    tx4p_fifo_sync_nff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack),
        .q     (a_sync)
    );

    // Full is taken from registered state only, so a same-cycle pop never frees a slot for the write.
    assign full = (count_q == CW'(DEPTH));
    assign push = v && !full;
    assign pop  = (state_q == ST_REQ) && a_sync;

    // NOTE: storage has no reset; entries are unreachable until written because count starts at zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= input_tx;
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                // A still-high ack is treated as an unfinished handshake.
                if (a_sync) begin
                    state_d = ST_WACK;
                end else if (count_q != '0) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    out_d   = mem_q[rd_ptr_q];
                end
            end
            ST_REQ: begin
                if (a_sync) begin
                    state_d = ST_WACK;
                    req_d   = 1'b0;
                end
            end
            ST_WACK: begin
                req_d = 1'b0;
                if (!a_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            req_q    <= 1'b0;
            f_q      <= 1'b0;
            ovf_q    <= 1'b0;
            a_prev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            out_q    <= out_d;
            req_q    <= req_d;
            a_prev_q <= a_sync;
            f_q      <= a_sync && !a_prev_q;
            ovf_q    <= ovf_q || (v && full);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    if (ACK_TIMEOUT > 0) begin : g_tmo
        localparam int TW = $clog2(ACK_TIMEOUT + 1);

        logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
        logic          tmo_q;

        // Counter restarts on entry to REQ and saturates at the limit.
        always_comb begin
            tmo_cnt_d = tmo_cnt_q;
            if (state_q != ST_REQ && state_d == ST_REQ) begin
                tmo_cnt_d = '0;
            end else if (state_q == ST_REQ && tmo_cnt_q != TW'(ACK_TIMEOUT)) begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                tmo_cnt_q <= '0;
                tmo_q     <= 1'b0;
            end else begin
                tmo_cnt_q <= tmo_cnt_d;
                tmo_q     <= tmo_q || (state_q == ST_REQ && tmo_cnt_d == TW'(ACK_TIMEOUT));
            end
        end

        assign tmo = tmo_q;
    end else begin : g_no_tmo
        assign tmo = 1'b0;
    end

    assign ready     = !full;
    assign count     = count_q;
    assign output_tx = out_q;
    assign req       = req_q;
    assign f         = f_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_tx4p_fifo.sv
// Scenario bench for tx4p_fifo: scoreboard of written words checked as each req rises.
module tb_tx4p_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       v, ack, v3, ack3;
    logic [7:0] input_tx, input3;
    logic       ready, req, f, ovf, tmo;
    logic       ready3, req3, f3, ovf3, tmo3;
    logic [2:0] count, count3;
    logic [7:0] output_tx, output3;

    int         errors = 0;
    int         checks = 0;
    int         model_count = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    tx4p_fifo #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .v(v), .input_tx(input_tx), .ready(ready), .count(count),
        .ack(ack), .output_tx(output_tx), .req(req), .f(f), .ovf(ovf), .tmo(tmo)
    );

    tx4p_fifo #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_STAGES(3), .ACK_TIMEOUT(16)) dut3 (
        .clk(clk), .reset(reset), .v(v3), .input_tx(input3), .ready(ready3), .count(count3),
        .ack(ack3), .output_tx(output3), .req(req3), .f(f3), .ovf(ovf3), .tmo(tmo3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; v = 1'b0; ack = 1'b0; v3 = 1'b0; ack3 = 1'b0;
        input_tx = '0; input3 = '0;
        tick(); tick();
        reset = 1'b0;
        sb.delete();
        model_count = 0;
    endtask

    task automatic write_word(input logic [7:0] data);
        v = 1'b1; input_tx = data;
        if (model_count < 4) begin
            sb.push_back(data);
            model_count++;
        end
        tick();
        v = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        logic [7:0] exp;
        while (req !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (req !== 1'b1) begin
            errors++; $display("FAIL %s_req_wait: req=%b expected 1", name, req);
        end else begin
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            checks++;
            if (output_tx !== exp) begin
                errors++; $display("FAIL %s_data: output_tx=%h expected %h", name, output_tx, exp);
            end
        end
    endtask

    task automatic finish_handshake(input string name);
        int n = 0;
        ack = 1'b1;
        while (req !== 1'b0 && n < 20) begin tick(); n++; end
        checks++;
        if (req !== 1'b0) begin
            errors++; $display("FAIL %s_req_fall: req=%b expected 0", name, req);
        end
        checks++;
        if (f !== 1'b1) begin
            errors++; $display("FAIL %s_f_pulse: f=%b expected 1", name, f);
        end
        model_count--;
        ack = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (req !== 1'b0)       begin errors++; $display("FAIL rst_req: got %b expected 0", req); end
        checks++; if (f !== 1'b0)         begin errors++; $display("FAIL rst_f: got %b expected 0", f); end
        checks++; if (output_tx !== 8'h0) begin errors++; $display("FAIL rst_out: got %h expected 00", output_tx); end
        checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL rst_ready: got %b expected 1", ready); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        checks++; if (tmo !== 1'b0)       begin errors++; $display("FAIL rst_tmo: got %b expected 0", tmo); end
    endtask

    task automatic test_single_word();
        write_word(8'hA5);                                  // after edge 0
        checks++; if (count !== 3'd1 || req !== 1'b0) begin
            errors++; $display("FAIL t1_edge0: count=%0d req=%b expected 1 0", count, req); end
        tick();                                             // after edge 1
        wait_req("t1");
        tick(); tick();                                     // after edge 3
        ack = 1'b1;
        tick(); tick();                                     // after edge 5
        checks++; if (req !== 1'b1 || count !== 3'd1) begin
            errors++; $display("FAIL t1_edge5: req=%b count=%0d expected 1 1", req, count); end
        tick();                                             // after edge 6
        checks++; if (req !== 1'b0 || f !== 1'b1) begin
            errors++; $display("FAIL t1_edge6: req=%b f=%b expected 0 1", req, f); end
        tick();                                             // after edge 7
        checks++; if (f !== 1'b0) begin
            errors++; $display("FAIL t1_edge7_f: f=%b expected 0", f); end
        ack = 1'b0;
        model_count--;
        repeat (5) tick();
        checks++; if (count !== 3'd0 || req !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL t1_idle: count=%0d req=%b ready=%b expected 0 0 1", count, req, ready); end
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (ready !== (model_count < 4)) begin
                errors++; $display("FAIL t2_ready_w%0d: ready=%b expected %b", i, ready, model_count < 4);
            end
            write_word(8'(i));
        end
        checks++; if (count !== 3'd4 || ready !== 1'b0 || ovf !== 1'b1) begin
            errors++; $display("FAIL t2_full: count=%0d ready=%b ovf=%b expected 4 0 1", count, ready, ovf); end
        for (int i = 0; i < 4; i++) begin
            wait_req("t2");
            finish_handshake("t2");
        end
        checks++; if (ovf !== 1'b1 || count !== 3'd0 || sb.size() != 0) begin
            errors++; $display("FAIL t2_end: ovf=%b count=%0d left=%0d expected 1 0 0", ovf, count, sb.size()); end
    endtask

    task automatic test_push_pop();
        apply_reset();
        for (int i = 0; i < 4; i++) write_word(8'h11 + 8'(i));
        wait_req("t3a");
        ack = 1'b1;
        tick(); tick();
        v = 1'b1; input_tx = 8'h55;                         // lands on the pop edge while full
        tick();
        v = 1'b0; ack = 1'b0; model_count--;
        checks++; if (req !== 1'b0 || count !== 3'd3 || ready !== 1'b1 || ovf !== 1'b1) begin
            errors++; $display("FAIL t3_full_pop: req=%b count=%0d ready=%b ovf=%b expected 0 3 1 1",
                               req, count, ready, ovf); end
        repeat (3) tick();
        wait_req("t3b");
        finish_handshake("t3b");
        wait_req("t3c");
        ack = 1'b1;
        tick(); tick();
        v = 1'b1; input_tx = 8'h66; sb.push_back(8'h66);
        tick();
        v = 1'b0; ack = 1'b0;
        checks++; if (count !== 3'd2 || req !== 1'b0) begin
            errors++; $display("FAIL t3_push_pop: count=%0d req=%b expected 2 0", count, req); end
        repeat (3) tick();
        wait_req("t3d");
        finish_handshake("t3d");
        wait_req("t3e");
        finish_handshake("t3e");
        checks++; if (count !== 3'd0 || sb.size() != 0) begin
            errors++; $display("FAIL t3_end: count=%0d left=%0d expected 0 0", count, sb.size()); end
    endtask

    task automatic test_timeout();
        apply_reset();
        write_word(8'h7E);                                  // after edge 0
        tick();                                             // req rose at edge 1
        wait_req("t4");
        repeat (15) tick();                                 // after edge 16
        checks++; if (tmo !== 1'b0) begin
            errors++; $display("FAIL t4_tmo_early: tmo=%b expected 0", tmo); end
        tick();                                             // after edge 17
        checks++; if (tmo !== 1'b1 || req !== 1'b1) begin
            errors++; $display("FAIL t4_tmo_set: tmo=%b req=%b expected 1 1", tmo, req); end
        repeat (10) tick();
        checks++; if (tmo !== 1'b1 || req !== 1'b1 || output_tx !== 8'h7E) begin
            errors++; $display("FAIL t4_hold: tmo=%b req=%b out=%h expected 1 1 7e", tmo, req, output_tx); end
        finish_handshake("t4");
        checks++; if (tmo !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL t4_after: tmo=%b count=%0d expected 1 0", tmo, count); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) write_word(8'h31 + 8'(i));
        checks++; if (req !== 1'b1 || count !== 3'd3) begin
            errors++; $display("FAIL t5_pre: req=%b count=%0d expected 1 3", req, count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (req !== 1'b0 || output_tx !== 8'h0 || count !== 3'd0 || ready !== 1'b1) begin
            errors++; $display("FAIL t5_async: req=%b out=%h count=%0d ready=%b expected 0 00 0 1",
                               req, output_tx, count, ready); end
        reset = 1'b0;
        sb.delete(); model_count = 0;
        repeat (10) tick();
        checks++; if (req !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL t5_after: req=%b count=%0d expected 0 0", req, count); end
    endtask

    task automatic test_sync_depth();
        apply_reset();
        v3 = 1'b1; input3 = 8'hC3;
        tick();                                             // after edge 0
        v3 = 1'b0;
        tick();                                             // after edge 1
        checks++; if (req3 !== 1'b1 || output3 !== 8'hC3) begin
            errors++; $display("FAIL t6_req: req=%b out=%h expected 1 c3", req3, output3); end
        tick(); tick();                                     // after edge 3
        ack3 = 1'b1;
        repeat (3) tick();                                  // after edge 6
        checks++; if (req3 !== 1'b1 || f3 !== 1'b0) begin
            errors++; $display("FAIL t6_edge6: req=%b f=%b expected 1 0", req3, f3); end
        tick();                                             // after edge 7
        checks++; if (req3 !== 1'b0 || f3 !== 1'b1) begin
            errors++; $display("FAIL t6_edge7: req=%b f=%b expected 0 1", req3, f3); end
        ack3 = 1'b0;
        repeat (6) tick();
        checks++; if (count3 !== 3'd0 || req3 !== 1'b0) begin
            errors++; $display("FAIL t6_end: count=%0d req=%b expected 0 0", count3, req3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_push_pop();
        test_timeout();
        test_reset_mid();
        test_sync_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
